// File: rtl/ahb_slave_mem_if.sv
// AHB bus bundle between the master side (address decoder / mux) and ahb_slave_mem.
// Hready is the bus-level ready fed back from the response mux.
interface ahb_slave_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    Hsel;
  logic [ADDR_WIDTH-1:0]   Haddr;
  logic                    HWrite;
  logic [2:0]              Hsize;
  logic [2:0]              Hburst;
  logic [1:0]              Htrans;
  logic [DATA_WIDTH/8-1:0] Hstrb;
  logic [DATA_WIDTH-1:0]   HWdata;
  logic                    Hready;
  logic                    Hreadyout;
  logic [1:0]              Hresp;
  logic [DATA_WIDTH-1:0]   HRdata;

  modport master (
    output Hsel, Haddr, HWrite, Hsize, Hburst, Htrans, Hstrb, HWdata, Hready,
    input  Hreadyout, Hresp, HRdata
  );

  modport slave (
    input  Hsel, Haddr, HWrite, Hsize, Hburst, Htrans, Hstrb, HWdata, Hready,
    output Hreadyout, Hresp, HRdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB slave with word-addressed on-chip memory, byte strobes, fixed wait states
// and the two-cycle ERROR response.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no data phase, or a zero-wait OKAY data phase completing now
// ST_WAIT | OKAY data phase; Hreadyout low until wait_cnt reaches zero
// ST_ERR1 | first ERROR cycle: Hreadyout=0, Hresp=ERROR
// ST_ERR2 | second ERROR cycle: Hreadyout=1, Hresp=ERROR
module ahb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic           Hclk,
  input  logic           Hreset,
  ahb_slave_mem_if.slave bus
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int BYTE_BITS = $clog2(STRB_W);
  localparam int IDX_BITS  = $clog2(MEM_DEPTH);
  localparam int TOP_BIT   = BYTE_BITS + IDX_BITS;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [3:0]            wait_cnt;
  logic [3:0]            wait_cnt_nx;
  logic                  dp_ok;
  logic                  dp_ok_nx;
  logic                  dp_write;
  logic [IDX_BITS-1:0]   dp_idx;
  logic [STRB_W-1:0]     dp_strb;

  logic                  ready_int;
  logic [1:0]            resp_int;
  logic                  accept;
  logic                  addr_oob;
  logic                  size_bad;
  logic                  misaligned;
  logic                  bad_access;
  logic [7:0]            align_mask;
  logic                  commit;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Anything above the top word index bit means the byte address is past the array.
  assign addr_oob   = |(bus.Haddr >> TOP_BIT);
  assign size_bad   = bus.Hsize > 3'(BYTE_BITS);
  assign align_mask = (8'd1 << bus.Hsize) - 8'd1;
  assign misaligned = |(bus.Haddr[7:0] & align_mask);
  assign bad_access = addr_oob | size_bad | misaligned;

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      dp_ok    <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      dp_ok    <= dp_ok_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    dp_ok_nx    = dp_ok;
    ready_int   = 1'b1;
    resp_int    = RESP_OKAY;
    accept      = 1'b0;

    case (state)
      ST_IDLE: begin
      end
      ST_WAIT: begin
        ready_int = (wait_cnt == 4'd0);
        if (wait_cnt != 4'd0) wait_cnt_nx = wait_cnt - 4'd1;
      end
      ST_ERR1: begin
        ready_int = 1'b0;
        resp_int  = RESP_ERROR;
        state_nx  = ST_ERR2;
      end
      ST_ERR2: begin
        resp_int = RESP_ERROR;
      end
      default: state_nx = ST_IDLE;
    endcase

    // Any cycle with Hreadyout high completes the current data phase and may
    // accept the next address phase in the same edge.
    if (ready_int) begin
      accept   = bus.Hsel & bus.Hready & bus.Htrans[1];
      state_nx = ST_IDLE;
      dp_ok_nx = 1'b0;
      if (accept) begin
        if (bad_access) begin
          state_nx = ST_ERR1;
        end else begin
          dp_ok_nx = 1'b1;
          if (WAIT_STATES > 0) begin
            state_nx    = ST_WAIT;
            wait_cnt_nx = 4'(WAIT_STATES);
          end
        end
      end
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_strb  <= '0;
    end else if (accept) begin
      dp_write <= bus.HWrite;
      dp_idx   <= bus.Haddr[BYTE_BITS +: IDX_BITS];
      dp_strb  <= bus.Hstrb;
    end
  end

  assign commit = dp_ok & ready_int & dp_write;

  // Memory is deliberately left out of reset; reset only blocks a pending write.
  always_ff @(posedge Hclk) begin
    if (!Hreset && commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (dp_strb[b]) mem[dp_idx][8*b +: 8] <= bus.HWdata[8*b +: 8];
      end
    end
  end

  // Combinational read so a read right after a write to the same word sees the new data.
  assign bus.HRdata    = (dp_ok && !dp_write) ? mem[dp_idx] : '0;
  assign bus.Hreadyout = ready_int;
  assign bus.Hresp     = resp_int;

  // SEQ beats are only legal inside a burst.
  a_seq_in_burst : assert property (@(posedge Hclk) disable iff (Hreset)
    accept |-> !(bus.Htrans == 2'b11 && bus.Hburst == 3'b000));

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a two-wait instance share one driver;
// table vectors feed a scoreboard checked as each data phase completes.
module tb_ahb_slave_mem;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BZ = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_slave_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  ahb_slave_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if2 ();

  ahb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0))
    u_ws0 (.Hclk(clk), .Hreset(rst), .bus(if0));
  ahb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(2))
    u_ws2 (.Hclk(clk), .Hreset(rst), .bus(if2));

  logic        hsel;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [3:0]  hstrb;
  int          which;

  assign if0.Hsel   = hsel && (which == 0);
  assign if2.Hsel   = hsel && (which == 2);
  assign if0.Haddr  = haddr;   assign if2.Haddr  = haddr;
  assign if0.HWrite = hwrite;  assign if2.HWrite = hwrite;
  assign if0.Hsize  = hsize;   assign if2.Hsize  = hsize;
  assign if0.Hburst = hburst;  assign if2.Hburst = hburst;
  assign if0.Htrans = htrans;  assign if2.Htrans = htrans;
  assign if0.Hstrb  = hstrb;   assign if2.Hstrb  = hstrb;
  assign if0.HWdata = hwdata;  assign if2.HWdata = hwdata;
  assign if0.Hready = if0.Hreadyout;
  assign if2.Hready = if2.Hreadyout;

  logic        rdy;
  logic [1:0]  resp;
  logic [31:0] rdata;
  assign rdy   = (which == 0) ? if0.Hreadyout : if2.Hreadyout;
  assign resp  = (which == 0) ? if0.Hresp     : if2.Hresp;
  assign rdata = (which == 0) ? if0.HRdata    : if2.HRdata;

  typedef struct {
    int          id;
    logic        sel;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_waits;
  } vec_t;

  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   next_id = 0;
  int   first_acc = 0;
  int   last_done = 0;
  int   low_cnt = 0;
  logic resp_bad = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic [2:0] burst,
                              input logic wr, input logic [2:0] size, input logic [31:0] addr,
                              input logic [3:0] strb, input logic [31:0] wdata,
                              input logic [1:0] eresp, input logic [31:0] erdata, input int ewaits);
    vec_t v;
    v.id = next_id; next_id++;
    v.sel = sel; v.trans = trans; v.burst = burst; v.write = wr; v.size = size;
    v.addr = addr; v.strb = strb; v.wdata = wdata;
    v.exp_resp = eresp; v.exp_rdata = erdata; v.exp_waits = ewaits;
    return v;
  endfunction

  // Scoreboard monitor: one data phase in flight, checked on its completing cycle.
  always @(negedge clk) begin : mon
    logic bad_now;
    if (rst || sb.size() == 0) begin
      low_cnt  <= 0;
      resp_bad <= 1'b0;
    end else begin
      bad_now = resp_bad || (resp !== sb[0].exp_resp);
      if (!rdy) begin
        low_cnt  <= low_cnt + 1;
        resp_bad <= bad_now;
      end else begin
        chk($sformatf("resp_%0d", sb[0].id), 32'(resp), 32'(sb[0].exp_resp));
        chk($sformatf("resp_every_cycle_%0d", sb[0].id), 32'(bad_now), 32'd0);
        chk($sformatf("waits_%0d", sb[0].id), 32'(low_cnt), 32'(sb[0].exp_waits));
        chk($sformatf("rdata_%0d", sb[0].id), rdata, sb[0].exp_rdata);
        if (sb[0].trans[1]) last_done <= cyc;
        void'(sb.pop_front());
        low_cnt  <= 0;
        resp_bad <= 1'b0;
      end
    end
  end

  task automatic drive(input vec_t q[$]);
    bit got_first;
    got_first = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      int   n;
      logic r;
      n = 0;
      r = 1'b0;
      hsel = q[i].sel; htrans = q[i].trans; hburst = q[i].burst; hwrite = q[i].write;
      hsize = q[i].size; haddr = q[i].addr; hstrb = q[i].strb;
      do begin
        @(negedge clk); r = rdy;
        @(posedge clk); #1; n++;
      end while (!r && n < 64);
      chk($sformatf("accept_%0d", q[i].id), 32'(r), 32'd1);
      if (q[i].write) hwdata = q[i].wdata;
      sb.push_back(q[i]);
      if (!got_first && q[i].trans[1]) begin
        first_acc = cyc;
        got_first = 1'b1;
      end
    end
    hsel = 1'b0; htrans = ID; hwrite = 1'b0; hburst = 3'd0;
    begin
      int n;
      n = 0;
      while (sb.size() > 0 && n < 64) begin
        @(negedge clk); n++;
      end
    end
    chk("drain", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  vec_t t0[$];
  vec_t t2w[$];
  vec_t t2b[$];
  vec_t t2e[$];
  vec_t t2r[$];

  initial begin
    // zero-wait instance: back-to-back RAW, strobes, errors, boundaries, non-transfers
    t0.push_back(mk(1, NS, 3'd0, 1, 3'd2, 32'h10,  4'hF, 32'hDEADBEEF, 2'b00, 32'h0, 0));
    t0.push_back(mk(1, NS, 3'd0, 0, 3'd2, 32'h10,  4'h0, 32'h0,        2'b00, 32'hDEADBEEF, 0));
    t0.push_back(mk(1, NS, 3'd0, 1, 3'd2, 32'h20,  4'hF, 32'h11223344, 2'b00, 32'h0, 0));
    t0.push_back(mk(1, NS, 3'd0, 1, 3'd2, 32'h20,  4'b0101, 32'hAABBCCDD, 2'b00, 32'h0, 0));
    t0.push_back(mk(1, NS, 3'd0, 0, 3'd2, 32'h20,  4'h0, 32'h0,        2'b00, 32'h11BB33DD, 0));
    t0.push_back(mk(1, NS, 3'd0, 1, 3'd2, 32'h0,   4'hF, 32'h01020304, 2'b00, 32'h0, 0));
    t0.push_back(mk(1, NS, 3'd0, 0, 3'd2, 32'h400, 4'h0, 32'h0,        2'b01, 32'h0, 1));
    t0.push_back(mk(1, NS, 3'd0, 1, 3'd2, 32'h400, 4'hF, 32'h12345678, 2'b01, 32'h0, 1));
    t0.push_back(mk(1, NS, 3'd0, 1, 3'd2, 32'h2,   4'hF, 32'hFFFFFFFF, 2'b01, 32'h0, 1));
    t0.push_back(mk(1, NS, 3'd0, 1, 3'd3, 32'h10,  4'hF, 32'hFFFFFFFF, 2'b01, 32'h0, 1));
    t0.push_back(mk(1, NS, 3'd0, 1, 3'd2, 32'h3FC, 4'hF, 32'hCAFEF00D, 2'b00, 32'h0, 0));
    t0.push_back(mk(1, NS, 3'd0, 0, 3'd2, 32'h3FC, 4'h0, 32'h0,        2'b00, 32'hCAFEF00D, 0));
    t0.push_back(mk(1, NS, 3'd0, 0, 3'd0, 32'h21,  4'h0, 32'h0,        2'b00, 32'h11BB33DD, 0));
    t0.push_back(mk(1, NS, 3'd0, 0, 3'd1, 32'h21,  4'h0, 32'h0,        2'b01, 32'h0, 1));
    t0.push_back(mk(1, NS, 3'd0, 0, 3'd1, 32'h22,  4'h0, 32'h0,        2'b00, 32'h11BB33DD, 0));
    t0.push_back(mk(1, ID, 3'd0, 1, 3'd2, 32'h10,  4'hF, 32'h0,        2'b00, 32'h0, 0));
    t0.push_back(mk(1, BZ, 3'd0, 1, 3'd2, 32'h10,  4'hF, 32'h0,        2'b00, 32'h0, 0));
    t0.push_back(mk(0, NS, 3'd0, 1, 3'd2, 32'h10,  4'hF, 32'h0,        2'b00, 32'h0, 0));
    t0.push_back(mk(1, NS, 3'd0, 0, 3'd2, 32'h10,  4'h0, 32'h0,        2'b00, 32'hDEADBEEF, 0));
    t0.push_back(mk(1, NS, 3'd0, 0, 3'd2, 32'h0,   4'h0, 32'h0,        2'b00, 32'h01020304, 0));

    // two-wait instance
    t2w.push_back(mk(1, NS, 3'd0, 1, 3'd2, 32'h0, 4'hF, 32'hA0A0A0A0, 2'b00, 32'h0, 2));
    t2w.push_back(mk(1, NS, 3'd0, 1, 3'd2, 32'h4, 4'hF, 32'hB1B1B1B1, 2'b00, 32'h0, 2));
    t2w.push_back(mk(1, NS, 3'd0, 1, 3'd2, 32'h8, 4'hF, 32'hC2C2C2C2, 2'b00, 32'h0, 2));
    t2w.push_back(mk(1, NS, 3'd0, 1, 3'd2, 32'hC, 4'hF, 32'hD3D3D3D3, 2'b00, 32'h0, 2));
    t2b.push_back(mk(1, NS, 3'd3, 0, 3'd2, 32'h0, 4'h0, 32'h0, 2'b00, 32'hA0A0A0A0, 2));
    t2b.push_back(mk(1, SQ, 3'd3, 0, 3'd2, 32'h4, 4'h0, 32'h0, 2'b00, 32'hB1B1B1B1, 2));
    t2b.push_back(mk(1, SQ, 3'd3, 0, 3'd2, 32'h8, 4'h0, 32'h0, 2'b00, 32'hC2C2C2C2, 2));
    t2b.push_back(mk(1, SQ, 3'd3, 0, 3'd2, 32'hC, 4'h0, 32'h0, 2'b00, 32'hD3D3D3D3, 2));
    t2e.push_back(mk(1, NS, 3'd0, 0, 3'd2, 32'h400, 4'h0, 32'h0,        2'b01, 32'h0, 1));
    t2e.push_back(mk(1, NS, 3'd0, 1, 3'd3, 32'h4,   4'hF, 32'h55555555, 2'b01, 32'h0, 1));
    t2e.push_back(mk(1, NS, 3'd0, 0, 3'd2, 32'h4,   4'h0, 32'h0,        2'b00, 32'hB1B1B1B1, 2));
    t2r.push_back(mk(1, NS, 3'd0, 0, 3'd2, 32'h8,   4'h0, 32'h0,        2'b00, 32'hC2C2C2C2, 2));

    which = 0;
    hsel = 1'b0; htrans = ID; hburst = 3'd0; hsize = 3'd2; hwrite = 1'b0;
    haddr = 32'h0; hwdata = 32'h0; hstrb = 4'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_ws0", 32'(if0.Hreadyout), 32'd1);
    chk("rst_resp_ws0",  32'(if0.Hresp),     32'd0);
    chk("rst_rdata_ws0", if0.HRdata,         32'd0);
    chk("rst_ready_ws2", 32'(if2.Hreadyout), 32'd1);
    chk("rst_resp_ws2",  32'(if2.Hresp),     32'd0);
    chk("rst_rdata_ws2", if2.HRdata,         32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    drive(t0);

    which = 2;
    drive(t2w);
    drive(t2b);
    chk("burst_data_phase_cycles", 32'(last_done - first_acc + 1), 32'd12);
    drive(t2e);

    // reset in the middle of a waited write: the write must be dropped
    hsel = 1'b1; htrans = NS; hburst = 3'd0; hwrite = 1'b1; hsize = 3'd2;
    haddr = 32'h8; hstrb = 4'hF;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = ID; hwrite = 1'b0; hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("midwait_ready", 32'(rdy), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midwait_rst_ready", 32'(rdy),   32'd1);
    chk("midwait_rst_resp",  32'(resp),  32'd0);
    chk("midwait_rst_rdata", rdata,      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    drive(t2r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
